// File: rtl/clkdiv_monitor_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clkdiv_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_N   = 4;
  localparam int DEF_TOL      = 1;
  localparam int DEF_SYNC_STG = 2;

  // Unsigned distance taken as larger minus smaller so it never wraps.
  function automatic logic within_tol(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] tol);
    logic [31:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/clkdiv_sync_edge.sv
// Input synchronizer for the signal under test, plus a history flop for
// rising-edge detection.
module clkdiv_sync_edge
  import clkdiv_monitor_pkg::*;
#(
  parameter int SYNC_STG = DEF_SYNC_STG
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STG-1:0] sync_q;
  logic                hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STG'(sig_i);
      hist_q <= sync_q[SYNC_STG-1];
    end
  end

  assign sync_o = sync_q[SYNC_STG-1];
  assign rise_o = sync_o & ~hist_q;

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures period and high time of a divided clock, compares them with the
// expected values and reports lock, per-period errors and a sticky timeout.
module clkdiv_monitor
  import clkdiv_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_N   = DEF_LOCK_N,
  parameter int TOL      = DEF_TOL,
  parameter int SYNC_STG = DEF_SYNC_STG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int MC_W = $clog2(LOCK_N + 1);
  localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_TMO = {{(CNT_W-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic             hdone_q, hdone_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             mv_q, mv_d, locked_q, locked_d, err_q, err_d, tmo_q, tmo_d;
  logic             sync, rise;
  logic [CNT_W-1:0] meas_period;
  logic             is_match;

  clkdiv_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (sig_in),
    .sync_o(sync),
    .rise_o(rise)
  );

  assign meas_period = cnt_q + 1'b1;
  assign is_match    = (meas_period == exp_period) && (exp_period >= CNT_W'(2)) &&
                       within_tol(32'(hcnt_q), 32'(exp_high), 32'(TOL));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    hdone_d  = hdone_q;
    mc_d     = mc_q;
    locked_d = locked_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      hdone_d  = 1'b0;
      mc_d     = '0;
      locked_d = 1'b0;
      tmo_d    = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = SEEK;
    end else begin
      locked_d = (mc_q == LOCK_C);
      // A rise takes priority over a timeout landing in the same cycle.
      if (rise) begin
        state_d = MEAS;
        cnt_d   = '0;
        hcnt_d  = CNT_W'(1);
        hdone_d = 1'b0;
        if (state_q == MEAS) begin
          period_d = meas_period;
          high_d   = hcnt_q;
          mv_d     = 1'b1;
          if (is_match) begin
            if (mc_q != LOCK_C) mc_d = mc_q + 1'b1;
          end else begin
            mc_d     = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
      end else if (cnt_q == CNT_TMO) begin
        state_d  = SEEK;
        cnt_d    = '0;
        hcnt_d   = '0;
        hdone_d  = 1'b1;
        mc_d     = '0;
        locked_d = 1'b0;
        err_d    = 1'b1;
        tmo_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (!sync)        hdone_d = 1'b1;
        else if (!hdone_q) hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      hdone_q  <= 1'b0;
      mc_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      hdone_q  <= hdone_d;
      mc_q     <= mc_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Directed scoreboard bench for clkdiv_monitor: expected measurements are
// queued as each rising edge is driven and checked when meas_valid pulses.
module tb_clkdiv_monitor;
  import clkdiv_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, sig_in;
  logic [7:0] exp_period, exp_high;
  logic [7:0] period, high_time;
  logic       meas_valid, locked, err, timeout;

  typedef struct {
    int p;
    int h;
    int e;
    int l;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   tmo_expected = 1'b0;

  clkdiv_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .exp_period(exp_period),
    .exp_high  (exp_high),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .err       (err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input int h, input int e, input int l);
    exp_t x;
    x.p = p; x.h = h; x.e = e; x.l = l;
    q.push_back(x);
  endtask

  // One period of sig_in starting with a rising edge; called at a negedge.
  task automatic per(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (meas_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_meas_valid", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("period", int'(period), cur.p);
          chk("high_time", int'(high_time), cur.h);
          chk("err_at_meas", int'(err), cur.e);
          chk("locked_at_meas", int'(locked), cur.l);
        end
      end else if (err && !tmo_expected) begin
        chk("stray_err", 1, 0);
      end
    end
  end

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    exp_period = 8'd3; exp_high = 8'd1;
    repeat (2) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);

    // 1 high / 2 low: lock after the 4th measurement
    per(1, 2);
    for (int i = 0; i < 4; i++) begin push(3, 1, 0, 0); per(1, 2); end
    push(3, 1, 0, 1); per(1, 2);

    // one 4-cycle period while locked, then relock
    push(3, 1, 0, 1); per(1, 3);
    push(4, 1, 1, 0); per(1, 2);
    for (int i = 0; i < 4; i++) begin push(3, 1, 0, 0); per(1, 2); end
    push(3, 1, 0, 1); per(1, 2);

    // high-time tolerance on both sides
    exp_high = 8'd2; push(3, 1, 0, 1); per(1, 2);
    exp_high = 8'd3; push(3, 1, 1, 0); per(2, 2);
    exp_period = 8'd4; exp_high = 8'd2; push(4, 2, 0, 0); per(2, 2);
    exp_high = 8'd0; push(4, 2, 1, 0); per(1, 2);

    // relock, then stick sig_in high
    exp_period = 8'd3; exp_high = 8'd1;
    for (int i = 0; i < 4; i++) begin push(3, 1, 0, 0); per(1, 2); end
    push(3, 1, 0, 1); per(1, 2);
    push(3, 1, 0, 1);
    tmo_expected = 1'b1;
    sig_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (meas_valid) begin found = 1'b1; break; end
    end
    chk("stuck_last_meas_seen", int'(found), 1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    chk("tmo_cycles_after_meas", n, 255);
    chk("tmo_timeout", int'(timeout), 1);
    chk("tmo_locked", int'(locked), 0);
    chk("tmo_state_seek", int'(dut.state_q), int'(SEEK));
    sig_in = 1'b0;
    @(negedge clk);
    tmo_expected = 1'b0;
    chk("tmo_sticky", int'(timeout), 1);

    // back to measuring, then drop en mid-period
    per(1, 2);
    push(3, 1, 0, 0); per(1, 2);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_low_timeout", int'(timeout), 0);
    chk("en_low_locked", int'(locked), 0);
    chk("en_low_cnt", int'(dut.cnt_q), 0);
    chk("en_low_period_hold", int'(period), 3);
    chk("en_low_high_hold", int'(high_time), 1);
    per(1, 2); per(1, 2);
    en = 1'b1;
    repeat (2) @(negedge clk);
    per(1, 2);
    push(3, 1, 0, 0); per(1, 2);

    // relock, then asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) begin push(3, 1, 0, 0); per(1, 2); end
    push(3, 1, 0, 1); per(1, 2);
    chk("prereset_locked", int'(locked), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_period", int'(period), 0);
    chk("async_rst_high", int'(high_time), 0);
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_meas_valid", int'(meas_valid), 0);
    chk("async_rst_err", int'(err), 0);
    chk("async_rst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
